// File: rtl/dac_if.sv
// rtl/dac_if.sv - request and DAC pin bundle for the dac driver; DAC_BUSY_EN adds busy
interface dac_if #(
    parameter int WIDTH = 16
);
    logic             trigger;
    logic [WIDTH-1:0] value;
    logic             sync;
    logic             din;
    logic             clk_out;
`ifdef DAC_BUSY_EN
    logic             busy;
`endif

`ifdef DAC_BUSY_EN
    modport master (output trigger, output value, input sync, input din, input clk_out, input busy);
    modport slave  (input trigger, input value, output sync, output din, output clk_out, output busy);
`else
    modport master (output trigger, output value, input sync, input din, input clk_out);
    modport slave  (input trigger, input value, output sync, output din, output clk_out);
`endif
endinterface

// File: rtl/dac.sv
// rtl/dac.sv - SYNC-framed MSB-first serial driver for a 16-bit SPI-style DAC; DAC_BUSY_EN adds busy
module dac #(
    parameter int WIDTH    = 16,
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    dac_if.slave bus
);
    localparam int DIV_W = 9;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] bit_cnt, bit_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic             trig_d;
    logic             start;

    logic             sync_q, sync_n;
    logic             din_q, din_n;
    logic             clk_out_q, clk_out_n;
`ifdef DAC_BUSY_EN
    logic             busy_q, busy_n;
`endif

    // A start is a rising edge of trigger; trig_d resets to 0 so a level high at reset release counts
    assign start = bus.trigger & ~trig_d;

    // Next-state, shift register, counters and next registered pin values
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        div_n   = div_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_n = bus.value;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == HALF_LAST) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_cnt == HALF_LAST) begin
                    div_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = GAP;
                    end else begin
                        shreg_n = {shreg[WIDTH-2:0], 1'b0};
                        bit_n   = bit_cnt + CNT_W'(1);
                        state_n = SHIFT_LO;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_n   = '0;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Pins are decoded from the next state so they change on the same edge as the state
        sync_n    = (state_n == IDLE) || (state_n == GAP);
        clk_out_n = (state_n == SHIFT_HI);
        din_n     = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? shreg_n[WIDTH-1] : 1'b0;
`ifdef DAC_BUSY_EN
        busy_n    = (state_n != IDLE);
`endif
    end

    // State, datapath and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            trig_d    <= 1'b0;
            sync_q    <= 1'b1;
            din_q     <= 1'b0;
            clk_out_q <= 1'b0;
`ifdef DAC_BUSY_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_n;
            div_cnt   <= div_n;
            trig_d    <= bus.trigger;
            sync_q    <= sync_n;
            din_q     <= din_n;
            clk_out_q <= clk_out_n;
`ifdef DAC_BUSY_EN
            busy_q    <= busy_n;
`endif
        end
    end

    assign bus.sync    = sync_q;
    assign bus.din     = din_q;
    assign bus.clk_out = clk_out_q;
`ifdef DAC_BUSY_EN
    assign bus.busy    = busy_q;
`endif
endmodule

// File: tb/tb_dac.sv
// tb/tb_dac.sv - scoreboard bench for dac at HALF_DIV=1 and HALF_DIV=3
module tb_dac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dac_if #(.WIDTH(16)) if1 ();
    dac_if #(.WIDTH(16)) if2 ();

    dac #(.WIDTH(16), .HALF_DIV(1)) u_dac1 (.clk(clk), .rst(rst), .bus(if1));
    dac #(.WIDTH(16), .HALF_DIV(3)) u_dac3 (.clk(clk), .rst(rst), .bus(if2));

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    int          low_cnt[2];
    int          edges[2];
    int          lo_len[2];
    int          hi_len[2];
    logic        in_frame[2];
    logic        prev_sync[2];
    logic        prev_ck[2];
    logic [15:0] word[2];
    logic [15:0] popped;
    int          gap_left = 0;
    logic        bprev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reconstructs frames from the pins of one DUT and compares them with the scoreboard
    task automatic mon(input int k, input logic s, input logic ck, input logic d, input int hd);
        if (rst) begin
            in_frame[k]  = 1'b0;
            prev_sync[k] = 1'b1;
            prev_ck[k]   = 1'b0;
            return;
        end
        if (s) check($sformatf("idle_pins%0d", k), {30'b0, ck, d}, 32'd0);
        if (prev_sync[k] && !s) begin
            in_frame[k] = 1'b1;
            low_cnt[k]  = 0;
            edges[k]    = 0;
            word[k]     = '0;
            lo_len[k]   = 0;
            hi_len[k]   = 0;
        end
        if (in_frame[k] && !s) begin
            low_cnt[k]++;
            if (!prev_ck[k] && ck) begin
                check($sformatf("lo_phase%0d", k), lo_len[k], hd);
                word[k] = {word[k][14:0], d};
                edges[k]++;
                hi_len[k] = 0;
            end
            if (prev_ck[k] && !ck) begin
                check($sformatf("hi_phase%0d", k), hi_len[k], hd);
                lo_len[k] = 0;
            end
            if (ck) hi_len[k]++;
            else    lo_len[k]++;
        end
        if (in_frame[k] && !prev_sync[k] && s) begin
            check($sformatf("sync_low%0d", k), low_cnt[k], 32 * hd);
            check($sformatf("edges%0d", k), edges[k], 16);
            if (k == 0) begin
                check("frame_expected0", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) begin
                    popped = exp_q0.pop_front();
                    check("word0", word[k], popped);
                end
            end else begin
                check("frame_expected1", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) begin
                    popped = exp_q1.pop_front();
                    check("word1", word[k], popped);
                end
            end
            in_frame[k] = 1'b0;
        end
        prev_sync[k] = s;
        prev_ck[k]   = ck;
    endtask

    // Samples both DUTs on the falling edge, away from the active edge
    always @(negedge clk) begin
        mon(0, if1.sync, if1.clk_out, if1.din, 1);
        mon(1, if2.sync, if2.clk_out, if2.din, 3);
`ifdef DAC_BUSY_EN
        if (rst) begin
            gap_left = 0;
            bprev    = 1'b1;
        end else begin
            if (!bprev && if2.sync) gap_left = 6;
            check("busy", if2.busy, (!if2.sync) || (gap_left > 0));
            if (if2.sync && gap_left > 0) gap_left--;
            bprev = if2.sync;
        end
`endif
    end

    initial begin
        if1.trigger = 1'b0;
        if1.value   = '0;
        if2.trigger = 1'b0;
        if2.value   = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sync", if1.sync, 1'b1);
        check("rst_clk_out", if1.clk_out, 1'b0);
        check("rst_din", if1.din, 1'b0);
        step(3);

        // Alternating pattern, then all ones, then all zeros
        if1.value = 16'h5555; if1.trigger = 1'b1; exp_q0.push_back(16'h5555);
        step(3); if1.trigger = 1'b0; step(40);
        if1.value = 16'hFFFF; if1.trigger = 1'b1; exp_q0.push_back(16'hFFFF);
        step(3); if1.trigger = 1'b0; step(40);
        if1.value = 16'h0000; if1.trigger = 1'b1; exp_q0.push_back(16'h0000);
        step(3); if1.trigger = 1'b0; step(40);

        // Value change after start and a retrigger mid-frame are both ignored
        if1.value = 16'h5555; if1.trigger = 1'b1; exp_q0.push_back(16'h5555);
        step(6); if1.value = 16'h1234;
        step(5); if1.trigger = 1'b0;
        step(1); if1.trigger = 1'b1;
        step(60); if1.trigger = 1'b0;
        step(5);

        // Reset in the middle of a frame aborts it
        if1.value = 16'hAAAA; if1.trigger = 1'b1;
        step(12); rst = 1'b1;
        step(1); rst = 1'b0;
        @(negedge clk);
        check("midrst_sync", if1.sync, 1'b1);
        check("midrst_clk_out", if1.clk_out, 1'b0);
        check("midrst_din", if1.din, 1'b0);
        if1.trigger = 1'b0;
        step(3);
        if1.value = 16'hA5C3; if1.trigger = 1'b1; exp_q0.push_back(16'hA5C3);
        step(3); if1.trigger = 1'b0; step(40);

        // Trigger held high through reset release starts exactly one frame
        if1.value = 16'h3C3C; if1.trigger = 1'b1; rst = 1'b1; exp_q0.push_back(16'h3C3C);
        step(2); rst = 1'b0;
        step(100); if1.trigger = 1'b0;
        step(5);

        // Slow serial clock on the second instance
        if2.value = 16'h5A3C; if2.trigger = 1'b1; exp_q1.push_back(16'h5A3C);
        step(3); if2.trigger = 1'b0; step(120);
        if2.value = 16'hC3A5; if2.trigger = 1'b1; exp_q1.push_back(16'hC3A5);
        step(3); if2.trigger = 1'b0; step(120);

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac.md
# dac

Serial-interface driver for an external 16-bit SPI-style DAC (AD5541/DAC8551 class: SYNC, SCLK and DIN pins). On each rising edge of `trigger`, the block latches a 16-bit code and shifts it out MSB first in one SYNC-framed burst, with a divided serial clock. It sits between the positioning logic that produces DAC codes and the board-level DAC pins.

## Interface
Parameters:
- `WIDTH`, default 16: bits per frame and width of `value`.
- `HALF_DIV`, default 1: `clk` cycles per half period of `clk_out`, range 1 to 255.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `trigger`, input, 1: conversion request. Rising-edge sensitive; synchronous to `clk`.
- `value`, input, WIDTH: code to send. Sampled only when a frame starts.
- `sync`, output, 1: active-low frame select to the DAC.
- `din`, output, 1: serial data to the DAC, MSB first.
- `clk_out`, output, 1: serial clock to the DAC. Idles low; the DAC samples `din` on its rising edge.
- `busy`, output, 1: present only with `DAC_BUSY_EN`.

## Operation
- Edge detect:
  - `trig_d` register is reset to 0.
  - A start event is `trigger & ~trig_d`.
  - Consequence: if `trigger` is already high when reset is released, that counts as a rising edge.
- State machine:
  - IDLE: `sync`=1, `clk_out`=0, `din`=0. On a start event, load `shreg <= value`, clear the bit counter, go to SHIFT_LO.
  - SHIFT_LO: `sync`=0, `clk_out`=0, `din`=`shreg[WIDTH-1]`. Hold for HALF_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: `sync`=0, `clk_out`=1, `din` unchanged. Hold for HALF_DIV cycles. Then:
    - if the bit counter equals WIDTH-1, go to GAP;
    - otherwise shift `shreg` left by 1, increment the counter, go to SHIFT_LO.
  - GAP: `sync`=1, `clk_out`=0, `din`=0. Hold for 2*HALF_DIV cycles, then go to IDLE.
- Start events arriving outside IDLE are discarded; they are not queued. `trig_d` keeps tracking `trigger` in every state, so a level still high on return to IDLE does not start a new frame.
- Changes on `value` after the start cycle do not affect the frame in progress.
- All outputs are registered, with no combinational path from input to output.
- Reset, including mid-frame: on the next `clk` edge, `sync`=1, `clk_out`=0, `din`=0, state=IDLE, `shreg`=0, counter=0, `trig_d`=0.

## Timing
Values below are for the defaults (WIDTH=16, HALF_DIV=1).
- Cycle N: `clk` edge on which `trigger`=1 and `trig_d`=0.
- N+1: `sync` falls and `din` = bit 15.
- N+2: `clk_out` rises; bit 15 is sampled.
- Each bit lasts 2*HALF_DIV cycles, so `din` changes only while `clk_out` is low.
- SYNC low time: WIDTH*2*HALF_DIV cycles, i.e. 32 for the defaults. `sync` rises at N+33.
- Exactly WIDTH rising edges of `clk_out` per frame.
- Minimum start-to-start spacing: (WIDTH+1)*2*HALF_DIV + 1 cycles, i.e. 35 for the defaults.
- Worked example: `clk` period 200 ns and a `trigger` period of 8 µs (40 cycles) gives one complete frame per trigger period.

## Configuration
- `DAC_BUSY_EN` defined:
  - adds output port `busy`;
  - `busy` is 1 in SHIFT_LO, SHIFT_HI and GAP, and 0 in IDLE and during reset;
  - it is registered and aligned with the `sync` fall at N+1.
- `DAC_BUSY_EN` undefined: the `busy` port does not exist; all other behaviour is identical.

## Test plan
- Reset, then `trigger` 0→1 with `value`=16'h5555:
  - `sync` low for exactly 32 cycles starting at N+1;
  - `din` sampled at the 16 `clk_out` rising edges reads 0,1,0,1,… (16'h5555).
- `value`=16'hFFFF, then 16'h0000, one trigger each: captured words are FFFF and 0000; `din`=0 in IDLE and GAP.
- Toggle `trigger` 1→0→1 at N+10; change `value` to 16'h1234 at N+5: a single frame still carries 5555, and no second frame follows.
- Assert `rst` at N+12 for one cycle:
  - next cycle `sync`=1, `clk_out`=0, `din`=0;
  - a later trigger yields a full, correct frame.
- `trigger` held high through reset release: one frame starts at the first post-reset cycle, and none after.
- HALF_DIV=3, with `DAC_BUSY_EN` on:
  - `clk_out` high and low phases are 3 cycles each;
  - `sync` is low for 96 cycles;
  - `busy` is high from the `sync` fall through the end of GAP.
